// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_shift_reg slice: mode and FSM state
// encodings plus the default register geometry, taps and seed.
package lfsr_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;
    localparam logic [7:0]  DEF_TAPS  = 8'hB8;
    localparam logic [7:0]  DEF_SEED  = 8'h01;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-value function for the shift register / Fibonacci LFSR.
// Serial shift and LFSR step share one shifter; only the incoming bit differs.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
    input  logic [WIDTH-1:0] cur,
    input  mode_t            mode,
    input  logic             dir,
    input  logic             serial_bit,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] nxt
);

    logic fb;
    logic in_bit;

    // Select the incoming bit and apply the requested operation
    always_comb begin
        fb     = ^(cur & TAPS);
        in_bit = (mode == MODE_LFSR) ? fb : serial_bit;
        nxt    = cur;
        case (mode)
            MODE_HOLD:              nxt = cur;
            MODE_SHIFT, MODE_LFSR:  nxt = dir ? {in_bit, cur[WIDTH-1:1]}
                                              : {cur[WIDTH-2:0], in_bit};
            MODE_LOAD:              nxt = data;
            default:                nxt = cur;
        endcase
    end

endmodule

// File: rtl/lfsr_shift_reg.sv
// Parametrised shift register / Fibonacci LFSR with a counted burst engine.
// Optional feature macro: LFSR_ZERO_GUARD_EN -- when defined, any LFSR step
// taken from the all-zero register reloads SEED instead of sticking at zero.
module lfsr_shift_reg
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
    parameter int unsigned      CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_bit,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_out,
    output logic [WIDTH-1:0] o_whole_reg,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_lockup
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    mode_t            step_mode;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] next_val;

    // Effective operation: user mode only in IDLE without a start request,
    // forced LFSR step while a burst runs, otherwise hold
    always_comb begin
        step_mode = MODE_HOLD;
        case (state)
            ST_IDLE: if (!i_start) step_mode = mode_t'(i_mode);
            ST_RUN:  step_mode = MODE_LFSR;
            default: step_mode = MODE_HOLD;
        endcase
    end

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .cur        (shreg),
        .mode       (step_mode),
        .dir        (i_dir),
        .serial_bit (i_wr_bit),
        .data       (i_wr_data),
        .nxt        (step_val)
    );

    // Optional escape from the all-zero fixed point of the LFSR step
    always_comb begin
        next_val = step_val;
`ifdef LFSR_ZERO_GUARD_EN
        if (step_mode == MODE_LFSR && shreg == '0) next_val = SEED;
`endif
    end

    // Register update, burst FSM, step counter and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= SEED;
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            shreg  <= next_val;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_count != '0) begin
                            state  <= ST_RUN;
                            cnt    <= i_count;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Outgoing bit follows the current shift direction
    always_comb begin
        o_out       = i_dir ? shreg[0] : shreg[WIDTH-1];
        o_whole_reg = shreg;
        o_busy      = busy_q;
        o_done      = done_q;
        o_lockup    = (shreg == '0);
    end

endmodule
